// File: rtl/sdram_arbit.sv
// Central SDRAM scheduler: shares the SDRAM pins between the init, refresh, write and
// read engines, runs the refresh interval timer and issues one-cycle grants.
module sdram_arbit #(
    parameter int AREF_PERIOD = 1500,
    parameter int CNT_W       = 11
) (
    input  logic        s_clk,
    input  logic        s_rst,
    input  logic        init_end,
    input  logic [3:0]  init_cmd,
    input  logic [11:0] init_addr,
    output logic        aref_req,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [11:0] aref_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [11:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic [15:0] wr_data,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [11:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_bank,
    output logic [11:0] sdram_addr,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe,
    output logic        aref_miss
);

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_t;

    localparam logic [3:0]       CMD_NOP  = 4'b0111;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AREF_PERIOD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             aref_req_q, aref_req_d;
    logic             aref_en_q, aref_en_d;
    logic             wr_en_q, wr_en_d;
    logic             rd_en_q, rd_en_d;
    logic             aref_miss_q, aref_miss_d;
    logic             cke_q;
    logic             timer_expire;

    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            aref_req_q  <= 1'b0;
            aref_en_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            aref_miss_q <= 1'b0;
            cke_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            aref_req_q  <= aref_req_d;
            aref_en_q   <= aref_en_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            aref_miss_q <= aref_miss_d;
            cke_q       <= 1'b1;
        end
    end

    // Ownership FSM; the grant is registered so it lines up with the first owned cycle.
    always_comb begin
        state_d   = state_q;
        aref_en_d = 1'b0;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req_q) begin
                    state_d   = ST_AREF;
                    aref_en_d = 1'b1;
                end else if (wr_req) begin
                    state_d = ST_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = ST_READ;
                    rd_en_d = 1'b1;
                end
            end
            ST_AREF: begin
                if (aref_end) state_d = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) state_d = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end) state_d = ST_ARBIT;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Refresh timer; a new expiry beats the grant clearing the pending flag.
    always_comb begin
        timer_expire = (state_q != ST_INIT) && (cnt_q == CNT_LAST);
        cnt_d        = cnt_q + CNT_W'(1);
        if (state_q == ST_INIT || timer_expire) cnt_d = '0;
        aref_req_d = aref_req_q;
        if (timer_expire)   aref_req_d = 1'b1;
        else if (aref_en_d) aref_req_d = 1'b0;
        aref_miss_d = timer_expire && aref_req_q;
    end

    // Pins are forced to NOP until the first clock after reset release.
    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_bank   = 2'b00;
        sdram_addr   = 12'd0;
        sdram_dq_out = 16'd0;
        sdram_dq_oe  = 1'b0;
        if (cke_q) begin
            case (state_q)
                ST_INIT: begin
                    sdram_cmd  = init_cmd;
                    sdram_addr = init_addr;
                end
                ST_AREF: begin
                    sdram_cmd  = aref_cmd;
                    sdram_addr = aref_addr;
                end
                ST_WRITE: begin
                    sdram_cmd    = wr_cmd;
                    sdram_addr   = wr_addr;
                    sdram_bank   = wr_bank;
                    sdram_dq_out = wr_data;
                    sdram_dq_oe  = 1'b1;
                end
                ST_READ: begin
                    sdram_cmd  = rd_cmd;
                    sdram_addr = rd_addr;
                    sdram_bank = rd_bank;
                end
                default: begin
                    sdram_cmd = CMD_NOP;
                end
            endcase
        end
    end

    assign sdram_cke = cke_q;
    assign aref_req  = aref_req_q;
    assign aref_en   = aref_en_q;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign aref_miss = aref_miss_q;

endmodule

// File: tb/tb_sdram_arbit.sv
// Randomized bench for sdram_arbit: the bench plays all four engines, predicts every
// cycle's pins and flags from an ownership model, and a monitor checks them.
module tb_sdram_arbit;

    localparam int P    = 200;
    localparam int NCYC = 15000;

    localparam int M_INIT  = 0;
    localparam int M_ARBIT = 1;
    localparam int M_AREF  = 2;
    localparam int M_WRITE = 3;
    localparam int M_READ  = 4;
    localparam int G_NONE  = -1;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [11:0] addr;
        logic [1:0]  bank;
        logic [15:0] dq;
        logic        oe;
        logic        cke;
        logic        areq;
        logic        aen;
        logic        wen;
        logic        ren;
        logic        miss;
    } exp_t;

    logic        s_clk = 1'b0;
    logic        s_rst = 1'b1;
    logic        init_end = 1'b0;
    logic [3:0]  init_cmd = 4'b0111;
    logic [11:0] init_addr = '0;
    logic        aref_req, aref_en, wr_en, rd_en;
    logic        aref_end = 1'b0;
    logic [3:0]  aref_cmd = 4'b0111;
    logic [11:0] aref_addr = '0;
    logic        wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]  wr_cmd = 4'b0111;
    logic [11:0] wr_addr = '0;
    logic [1:0]  wr_bank = '0;
    logic [15:0] wr_data = '0;
    logic        rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]  rd_cmd = 4'b0111;
    logic [11:0] rd_addr = '0;
    logic [1:0]  rd_bank = '0;
    logic        sdram_cke, sdram_dq_oe, aref_miss;
    logic [3:0]  sdram_cmd;
    logic [1:0]  sdram_bank;
    logic [11:0] sdram_addr;
    logic [15:0] sdram_dq_out;

    sdram_arbit #(.AREF_PERIOD(P), .CNT_W(8)) dut (
        .s_clk(s_clk), .s_rst(s_rst),
        .init_end(init_end), .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_req(aref_req), .aref_en(aref_en), .aref_end(aref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd),
        .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .rd_addr(rd_addr), .rd_bank(rd_bank),
        .sdram_cke(sdram_cke), .sdram_cmd(sdram_cmd), .sdram_bank(sdram_bank),
        .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out),
        .sdram_dq_oe(sdram_dq_oe), .aref_miss(aref_miss)
    );

    always #5 s_clk = ~s_clk;

    exp_t exp_q[$];
    int   assert_count = 0;
    int   fail_count   = 0;
    int   mon_cycle    = 0;
    bit   stim_done    = 1'b0;

    // Reference model: who owns the pins, which grant is showing, refresh bookkeeping.
    int m_mode = M_INIT, m_grant = G_NONE;
    bit m_pending = 0, m_miss = 0, m_cke = 0, m_timer_run = 0;
    int m_timer_start = 0;

    // Engine-side stimulus state (0 idle, 1 requesting, 2 owning).
    int eng_state[2], eng_left[2], eng_grants[2];
    bit eng_long[2];
    bit req_v[2], end_v[2];
    int aref_left = 0, rel_cycle = 0, rst_left = 0, mid_resets = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] want);
        assert_count++;
        if (act !== want) begin
            fail_count++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, mon_cycle, act, want);
        end
    endtask

    task automatic drive_engines();
        int own_mode;
        if (m_grant == M_AREF) begin
            aref_left = $urandom_range(1, 4);
            aref_end  = 1'b0;
        end else if (m_mode == M_AREF) begin
            aref_left--;
            aref_end = (aref_left == 0);
        end else begin
            aref_end = ($urandom_range(0, 39) == 0);
        end
        for (int e = 0; e < 2; e++) begin
            own_mode = (e == 0) ? M_WRITE : M_READ;
            req_v[e] = 1'b0;
            end_v[e] = 1'b0;
            case (eng_state[e])
                0: begin
                    if ($urandom_range(0, 3) == 0) begin
                        eng_state[e] = 1;
                        req_v[e]     = 1'b1;
                    end else begin
                        end_v[e] = ($urandom_range(0, 29) == 0);
                    end
                end
                1: begin
                    if (m_grant == own_mode) begin
                        eng_state[e] = 2;
                        eng_grants[e]++;
                        eng_long[e] = (e == 0 && eng_grants[e] == 4) || (e == 1 && eng_grants[e] == 15);
                        eng_left[e] = eng_long[e] ? 2 * P + 5 : $urandom_range(1, 8);
                    end else if ($urandom_range(0, 49) == 0) begin
                        eng_state[e] = 0;
                    end else begin
                        req_v[e] = 1'b1;
                        end_v[e] = ($urandom_range(0, 29) == 0);
                    end
                end
                default: begin
                    eng_left[e]--;
                    if (eng_left[e] == 0 || (!eng_long[e] && m_pending && $urandom_range(0, 1) == 0)) begin
                        end_v[e] = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            eng_state[e] = 1;
                            req_v[e]     = 1'b1;
                        end else begin
                            eng_state[e] = 0;
                        end
                    end
                end
            endcase
        end
        wr_req = req_v[0];
        wr_end = end_v[0];
        rd_req = req_v[1];
        rd_end = end_v[1];
    endtask

    task automatic apply_stimulus(input int cyc);
        exp_t e;
        bit   expire;
        int   next_mode, next_grant;
        if (cyc < 3) begin
            s_rst = 1'b1;
        end else if (rst_left > 0) begin
            s_rst = 1'b1;
            rst_left--;
        end else if (m_mode == M_WRITE && ((cyc >= 5000 && mid_resets == 0) || (cyc >= 10000 && mid_resets == 1))) begin
            s_rst    = 1'b1;
            rst_left = 1;
            mid_resets++;
        end else begin
            s_rst = 1'b0;
        end

        init_cmd  = 4'($urandom);   init_addr = 12'($urandom);
        aref_cmd  = 4'($urandom);   aref_addr = 12'($urandom);
        wr_cmd    = 4'($urandom);   wr_addr   = 12'($urandom);
        wr_bank   = 2'($urandom);   wr_data   = 16'($urandom);
        rd_cmd    = 4'($urandom);   rd_addr   = 12'($urandom);
        rd_bank   = 2'($urandom);

        if (s_rst) begin
            for (int i = 0; i < 2; i++) eng_state[i] = 0;
            wr_req = 0; wr_end = 0; rd_req = 0; rd_end = 0;
            aref_end = 0; init_end = 0; rel_cycle = 0;
        end else begin
            init_end = (rel_cycle >= 20);
            rel_cycle++;
            drive_engines();
        end

        e     = '0;
        e.cmd = 4'b0111;
        if (!s_rst) begin
            e.cke  = m_cke;
            e.areq = m_pending;
            e.aen  = (m_grant == M_AREF);
            e.wen  = (m_grant == M_WRITE);
            e.ren  = (m_grant == M_READ);
            e.miss = m_miss;
            if (m_cke) begin
                case (m_mode)
                    M_INIT:  begin e.cmd = init_cmd; e.addr = init_addr; end
                    M_AREF:  begin e.cmd = aref_cmd; e.addr = aref_addr; end
                    M_WRITE: begin
                        e.cmd = wr_cmd; e.addr = wr_addr; e.bank = wr_bank;
                        e.dq  = wr_data; e.oe = 1'b1;
                    end
                    M_READ:  begin e.cmd = rd_cmd; e.addr = rd_addr; e.bank = rd_bank; end
                    default: e.cmd = 4'b0111;
                endcase
            end
        end
        exp_q.push_back(e);

        if (s_rst) begin
            m_mode = M_INIT; m_grant = G_NONE; m_pending = 0;
            m_miss = 0; m_cke = 0; m_timer_run = 0;
        end else begin
            expire     = m_timer_run && (((cyc - m_timer_start) % P) == P - 1);
            next_mode  = m_mode;
            next_grant = G_NONE;
            case (m_mode)
                M_INIT: if (init_end) begin
                    next_mode     = M_ARBIT;
                    m_timer_run   = 1;
                    m_timer_start = cyc + 1;
                end
                M_ARBIT: begin
                    if (m_pending)   next_grant = M_AREF;
                    else if (wr_req) next_grant = M_WRITE;
                    else if (rd_req) next_grant = M_READ;
                    if (next_grant != G_NONE) next_mode = next_grant;
                end
                M_AREF:  if (aref_end) next_mode = M_ARBIT;
                M_WRITE: if (wr_end)   next_mode = M_ARBIT;
                M_READ:  if (rd_end)   next_mode = M_ARBIT;
                default: next_mode = M_INIT;
            endcase
            m_miss    = expire && m_pending;
            m_pending = expire ? 1'b1 : ((next_grant == M_AREF) ? 1'b0 : m_pending);
            m_mode    = next_mode;
            m_grant   = next_grant;
            m_cke     = 1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            eng_state[i] = 0; eng_left[i] = 0; eng_grants[i] = 0; eng_long[i] = 0;
        end
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(posedge s_clk);
            #1;
            apply_stimulus(cyc);
        end
        stim_done = 1'b1;
        @(negedge s_clk);
        #1;
        check_output("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

    // Monitor: every cycle the DUT drives the pins, so every cycle has one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge s_clk);
            if (exp_q.size() == 0) begin
                if (!stim_done && mon_cycle > 0) check_output("queue_empty", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_output("sdram_cmd",    32'(sdram_cmd),    32'(e.cmd));
                check_output("sdram_addr",   32'(sdram_addr),   32'(e.addr));
                check_output("sdram_bank",   32'(sdram_bank),   32'(e.bank));
                check_output("sdram_dq_out", 32'(sdram_dq_out), 32'(e.dq));
                check_output("sdram_dq_oe",  32'(sdram_dq_oe),  32'(e.oe));
                check_output("sdram_cke",    32'(sdram_cke),    32'(e.cke));
                check_output("aref_req",     32'(aref_req),     32'(e.areq));
                check_output("aref_en",      32'(aref_en),      32'(e.aen));
                check_output("wr_en",        32'(wr_en),        32'(e.wen));
                check_output("rd_en",        32'(rd_en),        32'(e.ren));
                check_output("aref_miss",    32'(aref_miss),    32'(e.miss));
                mon_cycle++;
            end
        end
    end

endmodule
